binning_2x2_avg: RTL and testbench

- Streaming video 2x2 binning filter. It averages each non-overlapping 2x2 block of a raster into one output pixel, halving width and height.
- Sits in the video filter chain between sync-based (de/hs/vs) pixel sources and sinks.
- Cascadable: its output stream is a legal input stream for another instance (2x2 -> 4x4).
- Includes a bypass mode.

---
 rtl/binning_2x2_avg.sv | 196 +++++++++++++++++++
 tb/tb_binning_2x2_avg.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binning_2x2_avg.sv
// binning_2x2_avg: streaming 2x2 box-average downscaler for de/hs/vs video.
// Even rows store horizontal pair sums in a half-width line buffer. Odd rows
// add the stored sum to the current pair and emit the quarter of the total.
// Output timing is a fixed two-clock pipeline, and a bypass mode uses the same
// latency. The sync outputs form a legal input stream for a cascaded instance.
module binning_2x2_avg #(
  parameter int DE_SPARSE     = 0,
  parameter int LINE_SIZE_MAX = 4096,
  parameter int PIXEL_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bypass,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam int PW    = PIXEL_WIDTH;
  localparam int CW    = $clog2(LINE_SIZE_MAX) + 1;
  localparam int AW    = $clog2(LINE_SIZE_MAX / 2);
  localparam int DEPTH = LINE_SIZE_MAX / 2;

  // Input-side tracking state
  logic [CW-1:0] r_col;
  logic          r_row_odd;
  logic          r_hs_prev;
  logic          r_vs_prev;
  logic          r_frame_ok;
  logic          r_bypass;
  logic [PW-1:0] r_prev_pix;

  // Line buffer of horizontal pair sums from the even row
  logic [PW:0]   r_line_buf [0:DEPTH-1];
  logic [PW:0]   r_buf_rd;

  // Stage-1 pipeline registers
  logic          r_s1_valid;
  logic          r_s1_hs;
  logic          r_s1_vs;
  logic [PW-1:0] r_s1_raw_pix;
  logic          r_s1_raw_de;
  logic          r_s1_raw_hs;
  logic          r_s1_raw_vs;

  logic          w_vs_rise;
  logic          w_hs_rise;
  logic          w_frame_act;
  logic          w_col_ok;
  logic          w_pix_ok;
  logic          w_odd_col;
  logic [AW-1:0] w_addr;
  logic [PW:0]   w_pair;
  logic [PW:0]   w_s1_pair;
  logic [PW+1:0] w_sum;
  logic [PW-1:0] w_avg;

  // A frame only counts once its vs_i rising edge has been seen. After a
  // mid-frame reset the rest of that frame is ignored.
  assign w_vs_rise   = vs_i & ~r_vs_prev;
  assign w_hs_rise   = hs_i & ~r_hs_prev;
  assign w_frame_act = vs_i & (r_frame_ok | w_vs_rise);
  assign w_col_ok    = (r_col < CW'(LINE_SIZE_MAX));
  assign w_pix_ok    = de_i & ~hs_i & w_frame_act & w_col_ok;
  assign w_odd_col   = r_col[0];
  assign w_addr      = r_col[AW:1];
  assign w_pair      = {1'b0, r_prev_pix} + {1'b0, di_i};
  assign w_sum       = {1'b0, r_buf_rd} + {1'b0, w_s1_pair};
  assign w_avg       = PW'(w_sum >> 2);

  // Edge detectors, frame qualification and the bypass select (sampled only between frames)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hs_prev  <= 1'b1;
      r_vs_prev  <= 1'b1;
      r_frame_ok <= 1'b0;
      r_bypass   <= 1'b0;
    end else begin
      r_hs_prev <= hs_i;
      r_vs_prev <= vs_i;
      if (!vs_i) begin
        r_frame_ok <= 1'b0;
        r_bypass   <= bypass;
      end else if (w_vs_rise) begin
        r_frame_ok <= 1'b1;
      end
    end
  end

  // Column counter: cleared in line blanking, saturates at the line-size limit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col <= '0;
    end else if (hs_i) begin
      r_col <= '0;
    end else if (de_i && w_col_ok) begin
      r_col <= r_col + CW'(1);
    end
  end

  // Row parity: even at frame start, toggles at every end of line
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row_odd <= 1'b0;
    end else if (!w_frame_act) begin
      r_row_odd <= 1'b0;
    end else if (w_hs_rise) begin
      r_row_odd <= ~r_row_odd;
    end
  end

  // Hold the first pixel of each horizontal pair
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev_pix <= '0;
    end else if (w_pix_ok && !w_odd_col) begin
      r_prev_pix <= di_i;
    end
  end

  // Line buffer: write pair sums on even rows, read the same slot every cycle
  always_ff @(posedge clk) begin
    if (w_pix_ok && w_odd_col && !r_row_odd) begin
      r_line_buf[w_addr] <= w_pair;
    end
    r_buf_rd <= r_line_buf[w_addr];
  end

  // Stage 1: qualify odd-row pair completions and mask hs during even rows
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_hs      <= 1'b1;
      r_s1_vs      <= 1'b0;
      r_s1_raw_pix <= '0;
      r_s1_raw_de  <= 1'b0;
      r_s1_raw_hs  <= 1'b1;
      r_s1_raw_vs  <= 1'b0;
    end else begin
      r_s1_valid   <= w_pix_ok & w_odd_col & r_row_odd;
      r_s1_hs      <= hs_i | ~r_row_odd | ~w_frame_act;
      r_s1_vs      <= w_frame_act;
      r_s1_raw_pix <= di_i;
      r_s1_raw_de  <= de_i;
      r_s1_raw_hs  <= hs_i;
      r_s1_raw_vs  <= vs_i;
    end
  end

  // With a dense input the pair sum is registered. With a sparse input, the held first
  // pixel is still stable one cycle later, so the pair is re-added next to the stage-1 pixel.
  generate
    if (DE_SPARSE == 0) begin : g_dense_pair
      logic [PW:0] r_s1_pair;
      // Register the horizontal pair sum alongside the buffer read
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_s1_pair <= '0;
        end else begin
          r_s1_pair <= w_pair;
        end
      end
      assign w_s1_pair = r_s1_pair;
    end else begin : g_sparse_pair
      assign w_s1_pair = {1'b0, r_prev_pix} + {1'b0, r_s1_raw_pix};
    end
  endgenerate

  // Stage 2: registered outputs, binned or bypassed; do_o holds between pixels
  always_ff @(posedge clk) begin
    if (!rst) begin
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b1;
      vs_o <= 1'b0;
    end else if (r_bypass) begin
      do_o <= r_s1_raw_pix;
      de_o <= r_s1_raw_de;
      hs_o <= r_s1_raw_hs;
      vs_o <= r_s1_raw_vs;
    end else begin
      de_o <= r_s1_valid;
      hs_o <= r_s1_hs;
      vs_o <= r_s1_vs;
      if (r_s1_valid) begin
        do_o <= w_avg;
      end
    end
  end

endmodule

// File: tb/tb_binning_2x2_avg.sv
// Self-checking bench for binning_2x2_avg. It uses random and directed frames and
// computes expected pixels from the 2x2 averaging rule with plain arithmetic.
module tb_binning_2x2_avg;
  localparam int PW  = 8;
  localparam int LSM = 16;
  localparam int HN  = 8192;

  logic          clk = 1'b0;
  logic          rst, bypass, de, hs, vs;
  logic [PW-1:0] di;
  logic [PW-1:0] do1, do2;
  logic          de1, hs1, vs1, de2, hs2, vs2;

  always #5 clk = ~clk;

  binning_2x2_avg #(.DE_SPARSE(0), .LINE_SIZE_MAX(LSM), .PIXEL_WIDTH(PW)) u_dut (
    .clk(clk), .rst(rst), .bypass(bypass), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
    .do_o(do1), .de_o(de1), .hs_o(hs1), .vs_o(vs1));

  binning_2x2_avg #(.DE_SPARSE(1), .LINE_SIZE_MAX(LSM), .PIXEL_WIDTH(PW)) u_dut2 (
    .clk(clk), .rst(rst), .bypass(1'b0), .di_i(do1), .de_i(de1), .hs_i(hs1), .vs_i(vs1),
    .do_o(do2), .de_o(de2), .hs_o(hs2), .vs_o(vs2));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int img [0:19][0:19];
  int tin [0:19][0:19];
  int exp_v[$];
  int exp_c[$];
  int got_v[$];
  int got_c[$];
  logic got_hs[$];
  logic got_vs[$];
  int got2_v[$];
  int hs1_falls = 0;
  logic hs1_prev = 1'b1;
  logic [PW+2:0] in_hist  [0:HN-1];
  logic [PW+2:0] out_hist [0:HN-1];

  // Input history and cycle count
  always @(posedge clk) begin
    in_hist[cyc % HN] <= {di, de, hs, vs};
    cyc <= cyc + 1;
  end

  // Output capture on the falling edge
  always @(negedge clk) begin
    out_hist[cyc % HN] = {do1, de1, hs1, vs1};
    if (de1) begin
      got_v.push_back(int'(do1));
      got_c.push_back(cyc);
      got_hs.push_back(hs1);
      got_vs.push_back(vs1);
    end
    if (de2) got2_v.push_back(int'(do2));
    if (!hs1 && hs1_prev) hs1_falls++;
    hs1_prev = hs1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame from img. gap_mode: 0 dense, 1 one idle, 2 random 0..2 idles.
  // If rst_row >= 0, a one-cycle reset is applied mid-line in that row.
  task automatic drive_frame(input int w, input int h, input int gap_mode,
                             input int rst_row, output int rst_cyc);
    int gaps;
    rst_cyc = 32'h7fffffff;
    tick(); vs = 1'b1; hs = 1'b1; de = 1'b0;
    tick(); tick();
    for (int y = 0; y < h; y++) begin
      tick(); hs = 1'b0; de = 1'b0;
      for (int x = 0; x < w; x++) begin
        if (y == rst_row && x == w / 2) begin
          tick(); de = 1'b0; rst = 1'b0; rst_cyc = cyc;
          tick();
          checks++;
          if (de1 !== 1'b0 || hs1 !== 1'b1 || vs1 !== 1'b0 || do1 !== 8'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got do=%0d de=%0b hs=%0b vs=%0b, expected do=0 de=0 hs=1 vs=0",
                     do1, de1, hs1, vs1);
          end
          rst = 1'b1;
        end
        tick(); de = 1'b1; di = PW'(img[y][x]); tin[y][x] = cyc;
        gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          tick(); de = 1'b0;
        end
      end
      tick(); de = 1'b0;
      tick(); hs = 1'b1;
      if (y == h - 1) vs = 1'b0;
      tick(); tick(); tick();
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  // Reference model: one output per complete 2x2 block, in raster order,
  // 2 clocks after its last input pixel; pixels beyond LSM per line are ignored.
  task automatic build_expected(input int w, input int h, input int rst_cyc);
    int we;
    exp_v.delete();
    exp_c.delete();
    we = (w < LSM) ? w : LSM;
    for (int y = 1; y < h; y += 2)
      for (int x = 1; x < we; x += 2)
        if (tin[y][x] + 2 <= rst_cyc) begin
          exp_v.push_back((img[y-1][x-1] + img[y-1][x] + img[y][x-1] + img[y][x]) / 4);
          exp_c.push_back(tin[y][x] + 2);
        end
  endtask

  task automatic test_reset();
    rst = 1'b0; bypass = 1'b0; di = '0; de = 1'b0; hs = 1'b1; vs = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (do1 !== 8'd0 || de1 !== 1'b0 || hs1 !== 1'b1 || vs1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1: got do=%0d de=%0b hs=%0b vs=%0b, expected 0 0 1 0", do1, de1, hs1, vs1);
    end
    checks++;
    if (do2 !== 8'd0 || de2 !== 1'b0 || hs2 !== 1'b1 || vs2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut2: got do=%0d de=%0b hs=%0b vs=%0b, expected 0 0 1 0", do2, de2, hs2, vs2);
    end
    rst = 1'b1;
    tick(); tick();
  endtask

  task automatic test_ramp();
    int rc, base, f0;
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = x;
    for (int fr = 0; fr < 2; fr++) begin
      base = got_v.size(); f0 = hs1_falls;
      drive_frame(16, 16, 0, -1, rc);
      build_expected(16, 16, rc);
      for (int i = 0; i < exp_v.size(); i++) begin
        int k;
        k = base + i;
        checks++;
        if (k >= got_v.size() || got_v[k] !== exp_v[i] || got_c[k] !== exp_c[i] ||
            got_hs[k] !== 1'b0 || got_vs[k] !== 1'b1) begin
          errors++;
          $display("FAIL ramp_pixel[%0d]: got %0d at cycle %0d, expected %0d at cycle %0d (hs=0 vs=1)",
                   i, (k < got_v.size()) ? got_v[k] : -1, (k < got_c.size()) ? got_c[k] : -1, exp_v[i], exp_c[i]);
        end
      end
      checks++;
      if (got_v.size() - base !== 64) begin
        errors++;
        $display("FAIL ramp_count: got %0d pixels, expected 64", got_v.size() - base);
      end
      checks++;
      if (hs1_falls - f0 !== 8) begin
        errors++;
        $display("FAIL ramp_lines: got %0d lines, expected 8", hs1_falls - f0);
      end
      checks++;
      if (do1 !== 8'd14) begin
        errors++;
        $display("FAIL ramp_hold: do_o is %0d after frame, expected 14", do1);
      end
    end
  endtask

  task automatic test_cascade();
    int rc, base2, f0;
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = x;
    base2 = got2_v.size(); f0 = hs1_falls;
    drive_frame(16, 16, 0, -1, rc);
    for (int i = 0; i < 16; i++) begin
      int k, e;
      k = base2 + i;
      e = 1 + 4 * (i % 4);
      checks++;
      if (k >= got2_v.size() || got2_v[k] !== e) begin
        errors++;
        $display("FAIL cascade_pixel[%0d]: got %0d, expected %0d", i, (k < got2_v.size()) ? got2_v[k] : -1, e);
      end
    end
    checks++;
    if (got2_v.size() - base2 !== 16) begin
      errors++;
      $display("FAIL cascade_count: got %0d pixels, expected 16", got2_v.size() - base2);
    end
    checks++;
    if (hs1_falls - f0 !== 8) begin
      errors++;
      $display("FAIL cascade_lines: second stage saw %0d lines, expected 8", hs1_falls - f0);
    end
  endtask

  task automatic test_truncation();
    int rc, base;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) img[y][x] = 255;
    img[0][0] = 0; img[0][1] = 0; img[1][0] = 0; img[1][1] = 3;
    img[0][2] = 1; img[0][3] = 1; img[1][2] = 1; img[1][3] = 2;
    base = got_v.size();
    drive_frame(8, 8, 0, -1, rc);
    build_expected(8, 8, rc);
    for (int i = 0; i < exp_v.size(); i++) begin
      int k;
      k = base + i;
      checks++;
      if (k >= got_v.size() || got_v[k] !== exp_v[i] || got_c[k] !== exp_c[i]) begin
        errors++;
        $display("FAIL trunc_pixel[%0d]: got %0d at cycle %0d, expected %0d at cycle %0d",
                 i, (k < got_v.size()) ? got_v[k] : -1, (k < got_c.size()) ? got_c[k] : -1, exp_v[i], exp_c[i]);
      end
    end
    checks++;
    if (got_v.size() - base !== 16 || got_v[base] !== 0 || got_v[base+1] !== 1 || got_v[base+2] !== 255) begin
      errors++;
      $display("FAIL trunc_direct: got count %0d first three %0d %0d %0d, expected 16 / 0 1 255",
               got_v.size() - base, got_v[base], got_v[base+1], got_v[base+2]);
    end
  endtask

  // Random images; gap_mode selects dense, sparse or random pacing.
  task automatic test_random(input string nm, input int w, input int h, input int gap_mode);
    int rc, base;
    for (int y = 0; y < h; y++) for (int x = 0; x < w; x++) img[y][x] = $urandom_range(0, 255);
    base = got_v.size();
    drive_frame(w, h, gap_mode, -1, rc);
    build_expected(w, h, rc);
    for (int i = 0; i < exp_v.size(); i++) begin
      int k;
      k = base + i;
      checks++;
      if (k >= got_v.size() || got_v[k] !== exp_v[i] || got_c[k] !== exp_c[i] ||
          got_hs[k] !== 1'b0 || got_vs[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s_pixel[%0d] (%0dx%0d): got %0d at cycle %0d, expected %0d at cycle %0d",
                 nm, i, w, h, (k < got_v.size()) ? got_v[k] : -1, (k < got_c.size()) ? got_c[k] : -1, exp_v[i], exp_c[i]);
      end
    end
    checks++;
    if (got_v.size() - base !== exp_v.size()) begin
      errors++;
      $display("FAIL %s_count (%0dx%0d): got %0d pixels, expected %0d", nm, w, h, got_v.size() - base, exp_v.size());
    end
  endtask

  task automatic test_bypass();
    int rc, c0, c1, base, f0;
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = x;
    bypass = 1'b1;
    tick(); tick();
    c0 = cyc; base = got_v.size(); f0 = hs1_falls;
    drive_frame(16, 16, 0, -1, rc);
    c1 = cyc;
    for (int c = c0; c <= c1 - 3; c++) begin
      checks++;
      if (out_hist[(c + 2) % HN] !== in_hist[c % HN]) begin
        errors++;
        $display("FAIL bypass_delay at cycle %0d: got {do,de,hs,vs}=%h, expected %h",
                 c + 2, out_hist[(c + 2) % HN], in_hist[c % HN]);
      end
    end
    checks++;
    if (got_v.size() - base !== 256 || hs1_falls - f0 !== 16) begin
      errors++;
      $display("FAIL bypass_geometry: got %0d pixels in %0d lines, expected 256 in 16",
               got_v.size() - base, hs1_falls - f0);
    end
    bypass = 1'b0;
    tick(); tick();
  endtask

  task automatic test_midreset();
    int rc, base;
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = x;
    base = got_v.size();
    drive_frame(16, 16, 0, 3, rc);
    build_expected(16, 16, rc);
    for (int i = 0; i < exp_v.size(); i++) begin
      int k;
      k = base + i;
      checks++;
      if (k >= got_v.size() || got_v[k] !== exp_v[i] || got_c[k] !== exp_c[i]) begin
        errors++;
        $display("FAIL midreset_pixel[%0d]: got %0d at cycle %0d, expected %0d at cycle %0d",
                 i, (k < got_v.size()) ? got_v[k] : -1, (k < got_c.size()) ? got_c[k] : -1, exp_v[i], exp_c[i]);
      end
    end
    checks++;
    if (got_v.size() - base !== 11) begin
      errors++;
      $display("FAIL midreset_count: got %0d pixels in aborted frame, expected 11", got_v.size() - base);
    end
    test_random("after_reset", 16, 16, 0);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_cascade();
    test_truncation();
    test_random("sparse_odd", 15, 15, 1);
    test_random("back_to_back", 16, 16, 0);
    test_random("beyond_limit", 20, 4, 0);
    for (int i = 0; i < 3; i++)
      test_random("random", $urandom_range(2, 20), $urandom_range(2, 16), 2);
    test_bypass();
    test_ramp();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
